// File: rtl/pulse_stretch_sched.sv
// pulse_stretch_sched
//   Shares one stretched-pulse output line between NREQ one-cycle event
//   sources. Each request is latched as pending, pending requests are
//   granted round-robin, and the winner's pulse is stretched to its
//   programmed length. A forced low gap of GAP_CYC cycles follows each
//   pulse; with GAP_CYC=0 consecutive pulses run back-to-back.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | line low, waiting for a pending request
//   STRETCH | out_pulse high, cnt counts the remaining high cycles - 1
//   GAP     | out_pulse low, cnt counts the remaining gap cycles - 1
//
// Ports
//   clk       clock, rising edge
//   rst_n     asynchronous active-low reset
//   req       per-requester 1-cycle request pulses
//   cfg_len   packed lengths, requester i at [i*LW +: LW]; 0 acts as 1
//   clr_ovf   synchronous clear of all ovf bits (a new overflow wins)
//   out_pulse shared stretched pulse (registered)
//   out_id    id of the current / last granted requester
//   pending   latched, not-yet-granted requests
//   ovf       sticky: request lost because it was already pending
//   busy      high in STRETCH or GAP
module pulse_stretch_sched #(
    parameter int NREQ    = 4,
    parameter int LW      = 8,
    parameter int GAP_CYC = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*LW-1:0]      cfg_len,
    input  logic                    clr_ovf,
    output logic                    out_pulse,
    output logic [$clog2(NREQ)-1:0] out_id,
    output logic [NREQ-1:0]         pending,
    output logic [NREQ-1:0]         ovf,
    output logic                    busy
);

    localparam int IDW = $clog2(NREQ);
    localparam logic [LW-1:0] GAP_LOAD = (GAP_CYC > 0) ? LW'(GAP_CYC - 1) : '0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STRETCH = 2'd1,
        GAP     = 2'd2
    } state_t;

    state_t          state, state_d;
    logic [LW-1:0]   cnt, cnt_d;
    logic [IDW-1:0]  ptr, ptr_d;
    logic [IDW-1:0]  id_d;
    logic            pulse_d;

    logic            upper_hit, lower_hit;
    logic [IDW-1:0]  upper_id, lower_id, win;
    logic [LW-1:0]   win_len;
    logic            try_grant;
    logic [NREQ-1:0] grant_clr;
    logic [NREQ-1:0] ovf_set;

    // Round-robin pick: lowest pending index above ptr, else lowest overall
    // (wrap, which also covers ptr itself). Descending loop leaves the
    // lowest matching index as the final assignment.
    always_comb begin
        upper_hit = 1'b0;
        lower_hit = 1'b0;
        upper_id  = '0;
        lower_id  = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (pending[i] && (IDW'(i) > ptr)) begin
                upper_hit = 1'b1;
                upper_id  = IDW'(i);
            end
            if (pending[i]) begin
                lower_hit = 1'b1;
                lower_id  = IDW'(i);
            end
        end
        win = upper_hit ? upper_id : lower_id;
    end

    always_comb begin
        win_len = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (IDW'(i) == win) begin
                win_len = cfg_len[i*LW +: LW];
            end
        end
    end

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        ptr_d     = ptr;
        id_d      = out_id;
        pulse_d   = out_pulse;
        grant_clr = '0;
        try_grant = 1'b0;

        case (state)
            IDLE: try_grant = 1'b1;
            STRETCH: begin
                if (cnt != '0) begin
                    cnt_d = cnt - 1'b1;
                end else begin
                    pulse_d = 1'b0;
                    if (GAP_CYC > 0) begin
                        state_d = GAP;
                        cnt_d   = GAP_LOAD;
                    end else begin
                        state_d   = IDLE;
                        try_grant = 1'b1;
                    end
                end
            end
            GAP: begin
                if (cnt != '0) begin
                    cnt_d = cnt - 1'b1;
                end else begin
                    // End of the gap grants directly, so the gap is exactly GAP_CYC.
                    state_d   = IDLE;
                    try_grant = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (try_grant && lower_hit) begin
            state_d        = STRETCH;
            pulse_d        = 1'b1;
            id_d           = win;
            ptr_d          = win;
            grant_clr[win] = 1'b1;
            cnt_d          = (win_len == '0) ? '0 : win_len - 1'b1;
        end
    end

    // A request that collides with an uncleared pending bit is lost.
    assign ovf_set = req & pending & ~grant_clr;
    assign busy    = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            ptr       <= IDW'(NREQ - 1);
            out_id    <= '0;
            out_pulse <= 1'b0;
            pending   <= '0;
            ovf       <= '0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            ptr       <= ptr_d;
            out_id    <= id_d;
            out_pulse <= pulse_d;
            pending   <= req | (pending & ~grant_clr);
            ovf       <= (clr_ovf ? '0 : ovf) | ovf_set;
        end
    end

endmodule
